// File: rtl/cr16_mmio_pkg.sv
// Shared constants for the CR16 memory-mapped I/O bank: register offsets
// inside the 64-word window and the ID register signature.
package cr16_mmio_pkg;

   localparam logic [5:0] OFF_OUT    = 6'h00;
   localparam logic [5:0] OFF_IN     = 6'h10;
   localparam logic [5:0] OFF_STATUS = 6'h20;
   localparam logic [5:0] OFF_MASK   = 6'h21;
   localparam logic [5:0] OFF_ID     = 6'h22;

   localparam logic [7:0] ID_SIG       = 8'hC5;
   localparam int         WINDOW_WORDS = 64;

   // ID word lets software discover the channel counts at run time.
   function automatic logic [15:0] id_word(input int n_out, input int n_in);
      return {4'(n_out - 1), 4'(n_in - 1), ID_SIG};
   endfunction

endpackage

// File: rtl/cr16_mmio_bank_if.sv
// CR16 16-bit memory bus as seen by the I/O bank (same timing as block RAM).
interface cr16_mmio_bank_if;
   logic [15:0] addr;
   logic        writeEn;
   logic        readEn;
   logic [15:0] writeData;
   logic [15:0] readData;
   logic        hit;

   modport master (output addr, writeEn, readEn, writeData, input readData, hit);
   modport slave  (input addr, writeEn, readEn, writeData, output readData, hit);
endinterface

// File: rtl/cr16_mmio_insync.sv
// One 16-bit input channel: multi-flop synchroniser, 1-cycle history and
// change detection, with change held off while the chain refills after reset.
module cr16_mmio_insync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        change
);

   localparam int QUIET = SYNC_STAGES + 1;
   localparam int QW    = $clog2(QUIET + 1);

   logic [15:0]   sync_q [SYNC_STAGES];
   logic [15:0]   hist_q;
   logic [QW-1:0] quiet_q;

   // Synchroniser chain, history copy and post-reset quiet down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         hist_q  <= '0;
         quiet_q <= QW'(QUIET);
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         hist_q <= sync_q[SYNC_STAGES-1];
         if (quiet_q != '0) quiet_q <= quiet_q - QW'(1);
      end
   end

   assign dout   = sync_q[SYNC_STAGES-1];
   // Until the counter expires the first value through the chain is not a change.
   assign change = (quiet_q == '0) && (dout != hist_q);

endmodule

// File: rtl/cr16_mmio_bank.sv
// CR16 MMIO bank: N_OUT writable output channels, N_IN synchronised input
// channels with sticky maskable change status and a registered interrupt.
module cr16_mmio_bank
   import cr16_mmio_pkg::*;
#(
   parameter int          N_OUT       = 2,
   parameter int          N_IN        = 2,
   parameter logic [15:0] BASE_ADDR   = 16'hFF00,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] OUT_RESET   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  reset,
   cr16_mmio_bank_if.slave       bus,
   input  logic [16*N_IN-1:0]    In_devices,
   output logic [16*N_OUT-1:0]   Out_devices,
   output logic                  irq
);

   if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
      $error("cr16_mmio_bank: N_OUT must be 1..16");
   end
   if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
      $error("cr16_mmio_bank: N_IN must be 1..16");
   end
   if (BASE_ADDR % WINDOW_WORDS != 0) begin : g_bad_base
      $error("cr16_mmio_bank: BASE_ADDR must be 64-word aligned");
   end

   logic [5:0]      off;
   logic            wr_hit;
   logic [15:0]     out_q  [N_OUT];
   logic [15:0]     in_val [N_IN];
   logic [N_IN-1:0] change;
   logic [N_IN-1:0] status_q;
   logic [N_IN-1:0] mask_q;
   logic [N_IN-1:0] w1c;
   logic [15:0]     rd_mux;

   assign bus.hit = (bus.addr[15:6] == BASE_ADDR[15:6]);
   assign off     = bus.addr[5:0];
   assign wr_hit  = bus.writeEn & bus.hit;

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      cr16_mmio_insync #(.SYNC_STAGES(SYNC_STAGES)) u_insync (
         .clk    (clk),
         .reset  (reset),
         .din    (In_devices[16*k +: 16]),
         .dout   (in_val[k]),
         .change (change[k])
      );
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign Out_devices[16*k +: 16] = out_q[k];
   end

   // Output channel registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_OUT; k++) out_q[k] <= OUT_RESET;
      end else if (wr_hit) begin
         for (int k = 0; k < N_OUT; k++)
            if (off == OFF_OUT + 6'(k)) out_q[k] <= bus.writeData;
      end
   end

   assign w1c = (wr_hit && off == OFF_STATUS) ? bus.writeData[N_IN-1:0] : '0;

   // Sticky status (a concurrent change beats the W1C) and mask register.
   always_ff @(posedge clk) begin
      if (reset) begin
         status_q <= '0;
         mask_q   <= '0;
      end else begin
         status_q <= (status_q & ~w1c) | change;
         if (wr_hit && off == OFF_MASK) mask_q <= bus.writeData[N_IN-1:0];
      end
   end

   // Interrupt is registered so it lags status/mask by one cycle.
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= |(status_q & mask_q);
   end

   // Read mux; unimplemented offsets and absent channels read as zero.
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < N_OUT; k++)
         if (off == OFF_OUT + 6'(k)) rd_mux = out_q[k];
      for (int k = 0; k < N_IN; k++)
         if (off == OFF_IN + 6'(k)) rd_mux = in_val[k];
      if (off == OFF_STATUS) rd_mux[N_IN-1:0] = status_q;
      if (off == OFF_MASK)   rd_mux[N_IN-1:0] = mask_q;
      if (off == OFF_ID)     rd_mux = id_word(N_OUT, N_IN);
   end

   // Registered read data with block-RAM-like 1-cycle latency.
   always_ff @(posedge clk) begin
      if (reset)            bus.readData <= '0;
      else if (bus.readEn)  bus.readData <= bus.hit ? rd_mux : 16'h0000;
   end

endmodule

// File: tb/tb_cr16_mmio_bank.sv
// Directed bench for cr16_mmio_bank. Reads push their expected data into a
// scoreboard queue; a monitor pops and compares one cycle after each strobe.
module tb_cr16_mmio_bank;

   localparam int          N_OUT   = 2;
   localparam int          N_IN    = 2;
   localparam int          SYNC    = 2;
   localparam logic [15:0] OUT_RST = 16'h00AA;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] In_devices;
   logic [31:0] Out_devices;
   logic        irq;

   cr16_mmio_bank_if bus_if ();

   cr16_mmio_bank #(
      .N_OUT       (N_OUT),
      .N_IN        (N_IN),
      .BASE_ADDR   (16'hFF00),
      .SYNC_STAGES (SYNC),
      .OUT_RESET   (OUT_RST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_if),
      .In_devices  (In_devices),
      .Out_devices (Out_devices),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus_if.addr      = a;
      bus_if.writeData = d;
      bus_if.writeEn   = 1'b1;
      tick();
      bus_if.writeEn   = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] e, input string name);
      bus_if.addr   = a;
      bus_if.readEn = 1'b1;
      sb_q.push_back('{val: e, name: name});
      tick();
      bus_if.readEn = 1'b0;
   endtask

   task automatic rdwr(input logic [15:0] a, input logic [15:0] d, input logic [15:0] e,
                       input string name);
      bus_if.addr      = a;
      bus_if.writeData = d;
      bus_if.writeEn   = 1'b1;
      bus_if.readEn    = 1'b1;
      sb_q.push_back('{val: e, name: name});
      tick();
      bus_if.writeEn   = 1'b0;
      bus_if.readEn    = 1'b0;
   endtask

   // Monitor: a read strobe seen on a rising edge is checked on the next falling edge.
   initial begin
      bit   fire;
      exp_t e;
      forever begin
         @(posedge clk);
         fire = bus_if.readEn && !reset;
         @(negedge clk);
         if (fire) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_errors++;
               $display("FAIL rd_unexpected got %h expected none", bus_if.readData);
            end else begin
               e = sb_q.pop_front();
               if (bus_if.readData !== e.val) begin
                  n_errors++;
                  $display("FAIL %s got %h expected %h", e.name, bus_if.readData, e.val);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset            = 1'b1;
      In_devices       = '0;
      bus_if.addr      = '0;
      bus_if.writeEn   = 1'b0;
      bus_if.readEn    = 1'b0;
      bus_if.writeData = '0;
      tick(3);
      check("rst_out",   Out_devices,     32'h00AA00AA);
      check("rst_rdata", bus_if.readData, 32'h0);
      check("rst_irq",   irq,             32'h0);
      reset = 1'b0;
      tick();

      // Output write and readback.
      wr(16'hFF01, 16'h1234);
      check("out1_wr", Out_devices, 32'h123400AA);
      rd(16'hFF01, 16'h1234, "rd_out1");
      tick();
      check("rdata_hold", bus_if.readData, 32'h1234);
      rd(16'hFF22, 16'h11C5, "rd_id");
      rd(16'hFF21, 16'h0000, "rd_mask0");

      // Input path and status with interrupt masked.
      In_devices[15:0] = 16'hBEEF;
      tick(4);
      rd(16'hFF10, 16'hBEEF, "rd_in0");
      rd(16'hFF11, 16'h0000, "rd_in1");
      rd(16'hFF20, 16'h0001, "rd_status_set");
      check("irq_masked", irq, 32'h0);

      // Unmask: irq one cycle after the mask register changes.
      wr(16'hFF21, 16'h0001);
      check("irq_mask_lat", irq, 32'h0);
      tick();
      check("irq_on", irq, 32'h1);

      // W1C lands on the same edge as a fresh change: set wins.
      In_devices[15:0] = 16'hCAFE;
      tick(2);
      wr(16'hFF20, 16'h0001);
      check("irq_set_wins", irq, 32'h1);
      rd(16'hFF20, 16'h0001, "rd_status_set_wins");
      check("irq_still_on", irq, 32'h1);

      // Clean clear.
      wr(16'hFF20, 16'h0001);
      check("irq_clr_lat", irq, 32'h1);
      tick();
      check("irq_off", irq, 32'h0);
      rd(16'hFF20, 16'h0000, "rd_status_clr");

      // Out-of-range, unimplemented and off-window reads return zero.
      rd(16'hFF01, 16'h1234, "rd_out1_b");
      rd(16'hFF1F, 16'h0000, "rd_in_oob");
      rd(16'hFF01, 16'h1234, "rd_out1_c");
      rd(16'hFF30, 16'h0000, "rd_unimpl");
      rd(16'hFF01, 16'h1234, "rd_out1_d");
      bus_if.addr = 16'h0100;
      #1;
      check("hit_low", bus_if.hit, 32'h0);
      bus_if.addr = 16'hFF3F;
      #1;
      check("hit_high", bus_if.hit, 32'h1);
      rd(16'h0100, 16'h0000, "rd_nohit");

      // Writes to read-only or absent registers are ignored.
      wr(16'hFF10, 16'h0000);
      rd(16'hFF10, 16'hCAFE, "rd_in_ro");
      wr(16'hFF05, 16'hFFFF);
      check("out_oob_wr", Out_devices, 32'h123400AA);

      // Simultaneous read and write: old value read, new value stored.
      rdwr(16'hFF00, 16'h7777, 16'h00AA, "rdwr_old");
      check("rdwr_new", Out_devices, 32'h12347777);

      // Reset in the middle of activity.
      In_devices[15:0] = 16'h1111;
      tick(4);
      check("irq_pre_rst", irq, 32'h1);
      rd(16'hFF01, 16'h1234, "rd_pre_rst");
      reset = 1'b1;
      tick();
      check("midrst_out",   Out_devices,     32'h00AA00AA);
      check("midrst_rdata", bus_if.readData, 32'h0);
      check("midrst_irq",   irq,             32'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < SYNC + 4; i++) rd(16'hFF20, 16'h0000, "rd_status_quiet");
      rd(16'hFF10, 16'h1111, "rd_in_after_rst");
      rd(16'hFF21, 16'h0000, "rd_mask_rst");
      check("irq_after_rst", irq, 32'h0);

      tick(2);
      check("sb_empty", sb_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
